// File: rtl/mmio_uart_bridge_pkg.sv
// Shared constants for the memory-port / UART bridge.
// Register map, status bit positions and UART FSM states.
package mmio_uart_bridge_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_ADDR_W = 13;
   localparam int BYTE_W     = 8;

   // Window is the top 2**WIN_BITS bytes of the address space
   localparam int WIN_BITS = 5;

   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_CTRL = 2'd1;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_VALID = 2;
   localparam int ST_OVERFLOW = 3;

   localparam int CTRL_CLR_RX  = 0;
   localparam int CTRL_CLR_OVF = 1;

   localparam int RX_VALID_BIT = 8;

   typedef enum logic [1:0] {
      U_IDLE,
      U_START,
      U_DATA,
      U_STOP
   } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
// Pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo
   import mmio_uart_bridge_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int W     = BYTE_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW])
               && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop frees the slot the push lands in, so full+pop still accepts
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mmio_uart_bridge.sv
// Splits core memory accesses between BRAM and a UART MMIO window,
// keeping one fixed load latency for both targets.
module mmio_uart_bridge
   import mmio_uart_bridge_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int LOAD_LATENCY = 1,
   parameter int CLK_PER_BIT  = 868,
   parameter int TXFIFO_DEPTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   st_data,
   input  logic [DATA_W/8-1:0] we,
   output logic [DATA_W-1:0]   ld_data,
   output logic [ADDR_W-1:0]   bram_addr,
   output logic [DATA_W-1:0]   bram_din,
   output logic [DATA_W/8-1:0] bram_we,
   input  logic [DATA_W-1:0]   bram_dout,
   output logic                uart_tx,
   input  logic                uart_rx
);

   localparam int CW = $clog2(CLK_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);

   logic       in_win;
   logic [1:0] reg_sel;
   logic       wr_data;
   logic       wr_ctrl;

   assign in_win  = &mem_addr[ADDR_W-1:WIN_BITS];
   assign reg_sel = mem_addr[4:3];
   assign wr_data = in_win && (reg_sel == REG_DATA) && we[0];
   assign wr_ctrl = in_win && (reg_sel == REG_CTRL) && we[0];

   assign bram_addr = mem_addr;
   assign bram_din  = st_data;
   assign bram_we   = in_win ? '0 : we;

   logic       tx_pop;
   logic       tx_full;
   logic       tx_empty;
   logic [7:0] fifo_dout;

   uart_tx_fifo #(
      .DEPTH (TXFIFO_DEPTH),
      .W     (BYTE_W)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_data),
      .din   (st_data[7:0]),
      .pop   (tx_pop),
      .dout  (fifo_dout),
      .full  (tx_full),
      .empty (tx_empty)
   );

   logic overflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (wr_data && tx_full && !tx_pop) begin
         overflow <= 1'b1;
      end else if (wr_ctrl && st_data[CTRL_CLR_OVF]) begin
         overflow <= 1'b0;
      end
   end

   uart_state_e tx_state;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift;
   logic          tx_line;
   logic          tx_bit_end;

   assign tx_bit_end = (tx_cnt == BIT_LAST);
   // Popping at the end of STOP chains frames with no idle gap
   assign tx_pop = !tx_empty
                && ((tx_state == U_IDLE)
                 || (tx_state == U_STOP && tx_bit_end));
   assign uart_tx = tx_line;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= U_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_line  <= 1'b1;
      end else begin
         unique case (tx_state)
            U_IDLE: begin
               if (tx_pop) begin
                  tx_shift <= fifo_dout;
                  tx_line  <= 1'b0;
                  tx_cnt   <= '0;
                  tx_state <= U_START;
               end
            end
            U_START: begin
               if (tx_bit_end) begin
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx_line  <= tx_shift[0];
                  tx_state <= U_DATA;
               end else begin
                  tx_cnt <= tx_cnt + CW'(1);
               end
            end
            U_DATA: begin
               if (tx_bit_end) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx_line  <= 1'b1;
                     tx_state <= U_STOP;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     tx_shift <= tx_shift >> 1;
                     tx_line  <= tx_shift[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt + CW'(1);
               end
            end
            U_STOP: begin
               if (tx_bit_end) begin
                  tx_cnt <= '0;
                  if (tx_pop) begin
                     tx_shift <= fifo_dout;
                     tx_line  <= 1'b0;
                     tx_state <= U_START;
                  end else begin
                     tx_state <= U_IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt + CW'(1);
               end
            end
         endcase
      end
   end

   logic rx_s1;
   logic rx_s2;
   logic rx_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= uart_rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   uart_state_e rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic [7:0]    rx_byte;
   logic          rx_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state <= U_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
      end else begin
         if (wr_ctrl && st_data[CTRL_CLR_RX]) rx_valid <= 1'b0;
         unique case (rx_state)
            U_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_cnt   <= '0;
                  rx_state <= U_START;
               end
            end
            U_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_s2 ? U_IDLE : U_DATA;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            U_DATA: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  if (rx_bit == 3'd7) rx_state <= U_STOP;
                  else rx_bit <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
            U_STOP: begin
               if (rx_cnt == BIT_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= U_IDLE;
                  // A fresh frame wins over a same-cycle clear
                  if (rx_s2) begin
                     rx_byte  <= rx_shift;
                     rx_valid <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + CW'(1);
               end
            end
         endcase
      end
   end

   logic [DATA_W-1:0] mmio_rd;

   always_comb begin
      mmio_rd = '0;
      if (in_win) begin
         case (reg_sel)
            REG_DATA: begin
               mmio_rd[RX_VALID_BIT] = rx_valid;
               mmio_rd[7:0]          = rx_byte;
            end
            REG_CTRL: begin
               mmio_rd[ST_OVERFLOW] = overflow;
               mmio_rd[ST_RX_VALID] = rx_valid;
               mmio_rd[ST_TX_EMPTY] = tx_empty;
               mmio_rd[ST_TX_FULL]  = tx_full;
            end
            default: ;
         endcase
      end
   end

   logic [LOAD_LATENCY-1:0] sel_pipe;
   logic [DATA_W-1:0]       mmio_pipe [LOAD_LATENCY];

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_pipe <= '0;
         for (int i = 0; i < LOAD_LATENCY; i++) begin
            mmio_pipe[i] <= '0;
         end
      end else begin
         sel_pipe[0]  <= in_win;
         mmio_pipe[0] <= mmio_rd;
         for (int i = 1; i < LOAD_LATENCY; i++) begin
            sel_pipe[i]  <= sel_pipe[i-1];
            mmio_pipe[i] <= mmio_pipe[i-1];
         end
      end
   end

   assign ld_data = sel_pipe[LOAD_LATENCY-1]
                  ? mmio_pipe[LOAD_LATENCY-1]
                  : bram_dout;

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Random-stimulus bench for mmio_uart_bridge with a register-map model.
// Two instances cover load latency 1 and 2 on shared stimulus.
module tb_mmio_uart_bridge;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [12:0] mem_addr;
   logic [63:0] st_data;
   logic [7:0]  we;
   logic        uart_rx;

   logic [63:0] ld1, ld2, bdout1, bdout2, bdin1, bdin2;
   logic [12:0] baddr1, baddr2;
   logic [7:0]  bwe1, bwe2;
   logic        tx1, tx2;
   logic [12:0] bq1, bq2a, bq2b;

   int checks = 0;
   int failures = 0;
   int rst_cnt = 0;

   bit          m_rx_valid, m_overflow, m_tx_empty, m_tx_full;
   logic [7:0]  m_rx_byte;
   logic [7:0]  got_q[$];
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   mmio_uart_bridge #(
      .DATA_W(64), .ADDR_W(13), .LOAD_LATENCY(1),
      .CLK_PER_BIT(CPB), .TXFIFO_DEPTH(16)
   ) dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr),
      .st_data(st_data), .we(we), .ld_data(ld1),
      .bram_addr(baddr1), .bram_din(bdin1), .bram_we(bwe1),
      .bram_dout(bdout1), .uart_tx(tx1), .uart_rx(uart_rx)
   );

   mmio_uart_bridge #(
      .DATA_W(64), .ADDR_W(13), .LOAD_LATENCY(2),
      .CLK_PER_BIT(CPB), .TXFIFO_DEPTH(16)
   ) dut2 (
      .clk(clk), .rst(rst), .mem_addr(mem_addr),
      .st_data(st_data), .we(we), .ld_data(ld2),
      .bram_addr(baddr2), .bram_din(bdin2), .bram_we(bwe2),
      .bram_dout(bdout2), .uart_tx(tx2), .uart_rx(uart_rx)
   );

   function automatic logic [63:0] pat(input logic [12:0] a);
      return {3'b0, a, 3'b0, a, 3'b0, a, 3'b0, a}
           ^ 64'hA5A5_5A5A_0F0F_F0F0;
   endfunction

   // BRAM model: read data appears LOAD_LATENCY cycles after address
   always @(posedge clk) begin
      bq1  <= mem_addr;
      bq2a <= mem_addr;
      bq2b <= bq2a;
      if (rst) rst_cnt <= rst_cnt + 1;
   end
   assign bdout1 = pat(bq1);
   assign bdout2 = pat(bq2b);

   function automatic logic [63:0] model_read(input logic [12:0] a);
      if (a[12:5] != 8'hFF) return pat(a);
      case (a[4:3])
         2'd0: return {55'b0, m_rx_valid, m_rx_byte};
         2'd1: return {60'b0, m_overflow, m_rx_valid,
                       m_tx_empty, m_tx_full};
         default: return 64'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [12:0] a, input logic [63:0] d,
                         input logic [7:0] m);
      @(negedge clk);
      mem_addr = a; st_data = d; we = m;
      @(negedge clk);
      we = '0; mem_addr = '0;
   endtask

   task automatic bus_rd(input logic [12:0] a, input string tag);
      logic [63:0] e;
      @(negedge clk);
      mem_addr = a; we = '0;
      e = model_read(a);
      @(negedge clk);
      check({tag, "_l1"}, ld1, e);
      @(negedge clk);
      check({tag, "_l2"}, ld2, e);
      mem_addr = '0;
   endtask

   task automatic wait_tx_low(input string tag);
      int t = 0;
      while (tx1 !== 1'b0 && t < 200) begin
         @(negedge clk); t++;
      end
      check(tag, tx1, 1'b0);
   endtask

   task automatic wait_tx(input string tag, input int budget);
      int t = 0;
      int n = exp_q.size();
      logic [8:0] g;
      while (got_q.size() < n && t < budget) begin
         @(negedge clk); t++;
      end
      check({tag, "_n"}, got_q.size(), n);
      while (exp_q.size() > 0) begin
         g = (got_q.size() > 0) ? {1'b0, got_q.pop_front()} : 9'h1FF;
         check(tag, g, {1'b0, exp_q.pop_front()});
      end
      got_q.delete();
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Line monitor: samples each frame at mid-bit, drops frames hit by reset
   logic [7:0] mon_b;
   bit         mon_ab;
   int         mon_rc, mon_wt;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && tx1 === 1'b0) begin
            mon_ab = 1'b0;
            mon_rc = rst_cnt;
            for (int j = 0; j < 10; j++) begin
               mon_wt = (j == 0) ? 1 : CPB;
               for (int k = 0; k < mon_wt; k++) begin
                  @(negedge clk);
                  if (rst_cnt != mon_rc) mon_ab = 1'b1;
               end
               if (mon_ab) break;
               if (j == 0) check("tx_start", tx1, 1'b0);
               else if (j == 9) check("tx_stop", tx1, 1'b1);
               else mon_b[j-1] = tx1;
            end
            if (!mon_ab) got_q.push_back(mon_b);
         end
      end
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog expired");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      logic [7:0]  b;
      logic [12:0] a;
      logic [63:0] ex[$];
      int          cnt;
      mem_addr = '0; st_data = '0; we = '0; uart_rx = 1'b1;
      m_rx_valid = 0; m_overflow = 0; m_tx_full = 0;
      m_tx_empty = 1; m_rx_byte = '0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx1, 1'b1);
      check("rst_ld1", ld1, pat(13'h0));
      check("rst_ld2", ld2, pat(13'h0));
      rst = 1'b0;
      bus_rd(13'h1FE8, "rst_status");
      bus_rd(13'h1FE0, "rst_data");

      @(negedge clk);
      mem_addr = 13'h010; st_data = 64'h1122334455667788; we = 8'hFF;
      #1;
      check("bram_we", bwe1, 8'hFF);
      check("bram_addr", baddr1, 13'h010);
      check("bram_din", bdin1, 64'h1122334455667788);
      mem_addr = 13'h1FF0;
      #1;
      check("win_bram_we", bwe1, 8'h00);
      @(negedge clk);
      we = '0; mem_addr = '0;
      bus_rd(13'h010, "bram_rd");
      bus_rd(13'h1FF0, "reg2_rd");
      bus_rd(13'h1FF8, "reg3_rd");

      bus_wr(13'h1FE0, 64'h55, 8'h01);
      exp_q.push_back(8'h55);
      wait_tx("tx55", 200);
      repeat (4) @(negedge clk);
      bus_rd(13'h1FE8, "tx_done_status");

      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         bus_wr(13'h1FE0, {56'b0, b}, 8'h01);
         exp_q.push_back(b);
      end
      wait_tx("tx_rand", 400);
      repeat (4) @(negedge clk);

      b = 8'($urandom);
      bus_wr(13'h1FE0, {56'b0, b}, 8'h01);
      exp_q.push_back(b);
      wait_tx_low("full_first_low");
      cnt = 0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         b = 8'($urandom);
         mem_addr = 13'h1FE0; st_data = {56'b0, b}; we = 8'h01;
         if (cnt < 16) begin
            exp_q.push_back(b); cnt++;
         end else begin
            m_overflow = 1;
         end
      end
      @(negedge clk);
      we = '0; mem_addr = '0;
      m_tx_full = 1; m_tx_empty = 0;
      bus_rd(13'h1FE8, "full_status");
      bus_wr(13'h1FE8, 64'h2, 8'h01);
      m_overflow = 0;
      bus_rd(13'h1FE8, "ovf_clr_status");
      wait_tx("tx_full", 17 * 45 + 100);
      m_tx_full = 0; m_tx_empty = 1;
      repeat (4) @(negedge clk);
      bus_rd(13'h1FE8, "drained_status");

      send_rx(8'hA3, 1'b1);
      m_rx_valid = 1; m_rx_byte = 8'hA3;
      bus_rd(13'h1FE0, "rx_data");
      bus_rd(13'h1FE8, "rx_status");
      bus_wr(13'h1FE8, 64'h1, 8'h01);
      m_rx_valid = 0;
      bus_rd(13'h1FE0, "rx_cleared");
      send_rx(8'($urandom), 1'b0);
      bus_rd(13'h1FE0, "rx_bad_stop");
      @(negedge clk);
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (12) @(negedge clk);
      bus_rd(13'h1FE0, "rx_glitch");
      for (int i = 0; i < 2; i++) begin
         b = 8'($urandom);
         send_rx(b, 1'b1);
         m_rx_valid = 1; m_rx_byte = b;
      end
      bus_rd(13'h1FE0, "rx_overwrite");

      for (int i = 0; i < 42; i++) begin
         @(negedge clk);
         if (i >= 1 && i <= 40) check("mix_l1", ld1, ex[i-1]);
         if (i >= 2 && i <= 41) check("mix_l2", ld2, ex[i-2]);
         if (i < 40) begin
            if (i == 0) a = 13'h1FE8;
            else if (i == 1) a = 13'h020;
            else if (i % 2 == 0)
               a = {8'hFF, 2'($urandom), 3'($urandom)};
            else
               a = 13'($urandom_range(0, 13'h1FDF));
            mem_addr = a;
            ex.push_back(model_read(a));
         end else begin
            mem_addr = '0;
         end
      end

      @(negedge clk);
      for (int i = 0; i < 18; i++) begin
         mem_addr = 13'h1FE0; st_data = 64'($urandom); we = 8'h01;
         @(negedge clk);
      end
      we = '0; mem_addr = '0;
      m_overflow = 1; m_tx_full = 1; m_tx_empty = 0;
      bus_rd(13'h1FE8, "pre_rst_status");
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_tx", tx1, 1'b1);
      rst = 1'b0;
      m_overflow = 0; m_tx_full = 0; m_tx_empty = 1;
      m_rx_valid = 0; m_rx_byte = '0;
      bus_rd(13'h1FE8, "rst_mid_status");
      bus_rd(13'h1FE0, "rst_mid_data");
      repeat (60) @(negedge clk);
      check("rst_no_frames", got_q.size(), 0);
      check("rst_idle_tx", tx1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_uart_bridge.md
Name: mmio_uart_bridge

Overview:
- Sits directly downstream of the core's memory port: consumes mem_addr, st_data and the byte write enables, and returns ld_data.
- Splits each access between the data BRAM and a small MMIO window holding a UART transmitter with a TX FIFO and a one-byte RX buffer.
- Keeps load latency identical for both targets, so the core sees one fixed-latency memory.

Parameters:
- DATA_W, 64, data bus width (matches the core data width)
- ADDR_W, 13, byte address width presented to memory
- LOAD_LATENCY, 1, cycles from address to ld_data; must be >=1
- CLK_PER_BIT, 868, clock cycles per UART bit
- TXFIFO_DEPTH, 16, TX FIFO entries; must be a power of 2

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_addr  in  ADDR_W  byte address from the core
- st_data  in  DATA_W  store data from the core
- we  in  DATA_W/8  byte write enables from the core
- ld_data  out  DATA_W  load data to the core, valid LOAD_LATENCY cycles after the address
- bram_addr  out  ADDR_W  BRAM address, equal to mem_addr
- bram_din  out  DATA_W  BRAM write data, equal to st_data
- bram_we  out  DATA_W/8  BRAM byte enables; forced to 0 inside the MMIO window
- bram_dout  in  DATA_W  BRAM read data, LOAD_LATENCY after the address
- uart_tx  out  1  serial output, idle high
- uart_rx  in  1  serial input, asynchronous

Behaviour:
- Window decode: in_win = &mem_addr[ADDR_W-1:5] (top 32 bytes). reg = mem_addr[4:3].
  - reg0 = DATA
  - reg1 = STATUS/CTRL
  - reg2 and reg3 read 0 and ignore writes.
- Write DATA (in_win, reg0, we[0]=1): enqueue st_data[7:0] if the FIFO is not full. If full, drop the byte and set overflow (sticky).
- Write CTRL (in_win, reg1, we[0]=1):
  - st_data[0]=1 clears rx_valid.
  - st_data[1]=1 clears overflow.
- Reads have no side effects.
  - DATA read = {0, rx_valid, rx_byte[7:0]} (rx_valid in bit 8).
  - STATUS read = {0, overflow, rx_valid, tx_empty, tx_full} in bits 3..0.
- Load path:
  - MMIO read data and in_win are captured in a LOAD_LATENCY-deep shift pipeline.
  - ld_data = sel_pipe_out ? mmio_pipe_out : bram_dout.
  - Back-to-back mixed accesses must return the correct source every cycle.
- TX FIFO: circular buffer with (log2 depth + 1)-bit pointers; pointers wrap modulo 2*depth.
  - full when the pointers differ only in the MSB; empty when they are equal.
  - An enqueue while the TX engine pops in the same cycle is allowed, including when full: that enqueue is accepted.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty, pop a byte and go to START.
  - START: line low for CLK_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLK_PER_BIT cycles.
  - STOP: line high for CLK_PER_BIT cycles, then IDLE. Consecutive bytes are sent with no extra idle bit.
- RX:
  - 2-flop synchroniser, then FSM IDLE, START, DATA, STOP.
  - Falling edge in IDLE: go to START; sample at CLK_PER_BIT/2. If the line is high again, return to IDLE (glitch).
  - Then sample each data bit at mid-bit.
  - STOP sample: if high, latch rx_byte and set rx_valid, overwriting any unread byte. If low, discard the frame and set no flag.
- Reset values (rst is synchronous):
  - uart_tx = 1; FIFO pointers = 0; overflow = 0; rx_valid = 0; rx_byte = 0; both FSMs = IDLE; load pipeline = 0, so ld_data = bram_dout.
- Reset mid-frame: the TX line returns high on the next edge and the frame is abandoned; RX drops the partial byte.
- bram_addr and bram_din are combinational pass-throughs; bram_we = in_win ? 0 : we.

Decomposition:
- Shared package / common_params header: DATA_W, ADDR_W, MMIO window base, register offsets, status bit indices, FSM state encodings.
- One natural sub-module: uart_tx_fifo (storage plus pointers, full/empty).
- TX/RX FSMs and decode stay in mmio_uart_bridge.

Test Plan:
- BRAM pass-through: write 0x1122334455667788 to addr 0x010 with we=0xFF → bram_we=0xFF. Read 0x010 → ld_data = bram_dout after LOAD_LATENCY. An MMIO-window write produces bram_we=0.
- TX: store 0x55 to 0x1FE0 with CLK_PER_BIT=4 → uart_tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. STATUS then reads 0x2.
- FIFO full: enqueue 17 bytes with TX stalled mid-first-frame → STATUS bit0=1 and bit3=1. Write CTRL 0x2 to 0x1FE8 → bit3 cleared. The 16 accepted bytes are transmitted in order.
- RX: drive frame 0xA3 → DATA read returns 0x1A3 and STATUS bit2=1. Write CTRL 0x1 → DATA reads 0x0A3.
- Mixed load latency: alternate reads of 0x1FE8 and 0x020 every cycle with LOAD_LATENCY=1 and 2 → each ld_data comes from the matching source.
- Reset mid-TX frame: assert rst for one cycle → uart_tx=1 next edge, FIFO empty, STATUS=0x2.
